// File: rtl/pred_reg_file_n.sv
// pred_reg_file_n - predicate register file with a valid bit per entry,
// channel/write-back write ports, a consume-clear port, a combinational FU read
// port and a one-entry multicast sender towards neighbour channels.
//
// Optional feature macro: PRED_BYPASS_EN
//   defined   : a write-back to pred_addr is forwarded to pred_out/pred_ok
//               in the same cycle.
//   undefined : the FU read port shows stored state only.
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   ch_p_in, in_sel     incoming channel predicates and one-hot channel select
//   put_in_addr         entry written from the selected channel
//   write_back_p        FU write-back enable
//   out2pred            FU write-back data
//   put_out_addr        FU write-back entry
//   clr_en, clr_addr    consume-clear of a valid bit
//   pred_addr           FU read address
//   pred_out, pred_ok   FU read data and its valid bit
//   send_req            start a send
//   send_addr, send_ch  entry to send and destination channel mask
//   ch_p_out            outgoing predicates, zero on idle channels
//   ch_p_valid          per-channel valid
//   ch_p_ready          per-channel ready
//   send_busy           sender is not idle
//   valid_cnt           number of valid entries
module pred_reg_file_n #(
  parameter int PW    = 4,
  parameter int DEPTH = 64,
  parameter int NCH   = 3,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH*PW-1:0] ch_p_in,
  input  logic [NCH-1:0]    in_sel,
  input  logic [AW-1:0]     put_in_addr,
  input  logic              write_back_p,
  input  logic [PW-1:0]     out2pred,
  input  logic [AW-1:0]     put_out_addr,
  input  logic              clr_en,
  input  logic [AW-1:0]     clr_addr,
  input  logic [AW-1:0]     pred_addr,
  output logic [PW-1:0]     pred_out,
  output logic              pred_ok,
  input  logic              send_req,
  input  logic [AW-1:0]     send_addr,
  input  logic [NCH-1:0]    send_ch,
  output logic [NCH*PW-1:0] ch_p_out,
  output logic [NCH-1:0]    ch_p_valid,
  input  logic [NCH-1:0]    ch_p_ready,
  output logic              send_busy,
  output logic [AW:0]       valid_cnt
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_SEND = 2'd2} state_e;

  logic [PW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW:0]      cnt_q, cnt_d;

  logic             ch_wr;
  logic [PW-1:0]    ch_data;

  state_e           state_q, state_d;
  logic [AW-1:0]    saddr_q, saddr_d;
  logic [NCH-1:0]   smask_q, smask_d;
  logic [PW-1:0]    sdata_q, sdata_d;
  logic [NCH-1:0]   chv_q, chv_d;

  function automatic logic [AW:0] popcnt(input logic [DEPTH-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Incoming channel select: only a strictly one-hot in_sel writes, so OR-ing
  // the masked slices yields exactly the selected channel's data.
  always_comb begin
    ch_wr   = (in_sel != '0) && ((in_sel & (in_sel - {{(NCH-1){1'b0}}, 1'b1})) == '0);
    ch_data = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_data = ch_data | (in_sel[k] ? ch_p_in[k*PW +: PW] : {PW{1'b0}});
    end
  end

  // Array/valid next state. Ordering gives the priorities: any set beats the
  // clear, and the write-back beats a channel write to the same entry.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    if (clr_en) begin
      valid_d[clr_addr] = 1'b0;
    end
    if (ch_wr) begin
      mem_d[put_in_addr]   = ch_data;
      valid_d[put_in_addr] = 1'b1;
    end
    if (write_back_p) begin
      mem_d[put_out_addr]   = out2pred;
      valid_d[put_out_addr] = 1'b1;
    end
    // Recount from the next bits so the count moves on the same edge.
    cnt_d = popcnt(valid_d);
  end

  // Storage registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // FU read port.
  always_comb begin
`ifdef PRED_BYPASS_EN
    if (write_back_p && (put_out_addr == pred_addr)) begin
      pred_out = out2pred;
      pred_ok  = 1'b1;
    end else begin
      pred_out = mem_q[pred_addr];
      pred_ok  = valid_q[pred_addr];
    end
`else
    pred_out = mem_q[pred_addr];
    pred_ok  = valid_q[pred_addr];
`endif
  end

  // Sender next state: WAIT polls the stored valid bit, SEND retires each
  // channel on its ready and leaves when nothing is pending.
  always_comb begin
    state_d = state_q;
    saddr_d = saddr_q;
    smask_d = smask_q;
    sdata_d = sdata_q;
    chv_d   = chv_q;
    case (state_q)
      S_IDLE: begin
        if (send_req && (send_ch != '0)) begin
          saddr_d = send_addr;
          smask_d = send_ch;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (valid_q[saddr_q]) begin
          sdata_d = mem_q[saddr_q];
          chv_d   = smask_q;
          state_d = S_SEND;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_SEND: begin
        chv_d = chv_q & ~ch_p_ready;
        if (chv_d == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        state_d = S_IDLE;
        chv_d   = '0;
      end
    endcase
  end

  // Sender registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      saddr_q <= '0;
      smask_q <= '0;
      sdata_q <= '0;
      chv_q   <= '0;
    end else begin
      state_q <= state_d;
      saddr_q <= saddr_d;
      smask_q <= smask_d;
      sdata_q <= sdata_d;
      chv_q   <= chv_d;
    end
  end

  // Outgoing data is zeroed on channels that are not currently valid.
  always_comb begin
    ch_p_out = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_p_out[k*PW +: PW] = chv_q[k] ? sdata_q : {PW{1'b0}};
    end
  end

  assign ch_p_valid = chv_q;
  assign send_busy  = (state_q != S_IDLE);
  assign valid_cnt  = cnt_q;

endmodule

// File: tb/tb_pred_reg_file_n.sv
module tb_pred_reg_file_n;
  localparam int PW = 4, DEPTH = 64, NCH = 3, AW = 6;

  logic              CLK, RST;
  logic [NCH*PW-1:0] ch_p_in;
  logic [NCH-1:0]    in_sel;
  logic [AW-1:0]     put_in_addr, put_out_addr, clr_addr, pred_addr, send_addr;
  logic              write_back_p, clr_en, send_req, pred_ok, send_busy;
  logic [PW-1:0]     out2pred, pred_out;
  logic [NCH-1:0]    send_ch, ch_p_valid, ch_p_ready;
  logic [NCH*PW-1:0] ch_p_out;
  logic [AW:0]       valid_cnt;

  int compared = 0;
  int mismatched = 0;

  // reference model: plain arrays
  logic [PW-1:0] m_mem [DEPTH];
  bit            m_val [DEPTH];

  pred_reg_file_n #(.PW(PW), .DEPTH(DEPTH), .NCH(NCH)) dut (
    .CLK(CLK), .RST(RST), .ch_p_in(ch_p_in), .in_sel(in_sel),
    .put_in_addr(put_in_addr), .write_back_p(write_back_p), .out2pred(out2pred),
    .put_out_addr(put_out_addr), .clr_en(clr_en), .clr_addr(clr_addr),
    .pred_addr(pred_addr), .pred_out(pred_out), .pred_ok(pred_ok),
    .send_req(send_req), .send_addr(send_addr), .send_ch(send_ch),
    .ch_p_out(ch_p_out), .ch_p_valid(ch_p_valid), .ch_p_ready(ch_p_ready),
    .send_busy(send_busy), .valid_cnt(valid_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_val[i]);
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
      m_val[i] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: apply the write rules to the model using the driven inputs.
  task automatic tick();
    @(posedge CLK);
    if (clr_en) m_val[clr_addr] = 1'b0;
    if ($countones(in_sel) == 1) begin
      for (int k = 0; k < NCH; k++)
        if (in_sel[k]) m_mem[put_in_addr] = ch_p_in[k*PW +: PW];
      m_val[put_in_addr] = 1'b1;
    end
    if (write_back_p) begin
      m_mem[put_out_addr] = out2pred;
      m_val[put_out_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    ch_p_in = '0; in_sel = '0; put_in_addr = '0; write_back_p = 1'b0;
    out2pred = '0; put_out_addr = '0; clr_en = 1'b0; clr_addr = '0;
    send_req = 1'b0; send_addr = '0; send_ch = '0; ch_p_ready = '0;
  endtask

  // Read port expectation from the model (with same-cycle forwarding if enabled).
  task automatic chk_read(input string tag);
    logic [PW-1:0] eo;
    logic          ek;
    eo = m_mem[pred_addr];
    ek = m_val[pred_addr];
`ifdef PRED_BYPASS_EN
    if (write_back_p && put_out_addr == pred_addr) begin
      eo = out2pred;
      ek = 1'b1;
    end
`endif
    chk({tag, "_out"}, 32'(pred_out), 32'(eo));
    chk({tag, "_ok"}, 32'(pred_ok), 32'(ek));
    chk({tag, "_cnt"}, 32'(valid_cnt), 32'(m_cnt()));
  endtask

  initial begin
    idle_inputs();
    pred_addr = '0;
    m_reset();
    // reset state
    RST = 1'b1;
    #12;
    chk("rst_cnt", 32'(valid_cnt), 32'd0);
    chk("rst_chv", 32'(ch_p_valid), 32'd0);
    chk("rst_chout", 32'(ch_p_out), 32'd0);
    chk("rst_busy", 32'(send_busy), 32'd0);
    chk("rst_ok", 32'(pred_ok), 32'd0);
    chk("rst_out", 32'(pred_out), 32'd0);
    RST = 1'b0;
    tick();

    // channel 1 write of 4'hA to entry 5
    in_sel = 3'b010; ch_p_in = 12'h0A0; put_in_addr = 6'd5;
    tick();
    idle_inputs(); pred_addr = 6'd5; #2;
    chk("ch1_out", 32'(pred_out), 32'hA);
    chk("ch1_ok", 32'(pred_ok), 32'd1);
    chk("ch1_cnt", 32'(valid_cnt), 32'd1);

    // channel write and write-back collide on entry 9
    in_sel = 3'b001; ch_p_in = 12'h003; put_in_addr = 6'd9;
    write_back_p = 1'b1; out2pred = 4'hC; put_out_addr = 6'd9;
    tick();
    idle_inputs(); pred_addr = 6'd9; #2;
    chk("coll_out", 32'(pred_out), 32'hC);
    chk("coll_cnt", 32'(valid_cnt), 32'd2);

    // non-one-hot select performs no write
    in_sel = 3'b011; ch_p_in = 12'h777; put_in_addr = 6'd11;
    tick();
    idle_inputs(); pred_addr = 6'd11; #2;
    chk("nonhot_ok", 32'(pred_ok), 32'd0);
    chk("nonhot_cnt", 32'(valid_cnt), 32'd2);

    // clear and write-back on entry 2 in the same cycle
    write_back_p = 1'b1; out2pred = 4'h1; put_out_addr = 6'd2;
    tick();
    clr_en = 1'b1; clr_addr = 6'd2; out2pred = 4'h5;
    tick();
    idle_inputs(); pred_addr = 6'd2; #2;
    chk("clrset_ok", 32'(pred_ok), 32'd1);
    chk("clrset_out", 32'(pred_out), 32'h5);
    chk("clrset_cnt", 32'(valid_cnt), 32'd3);

    // write-back 4'hF to entry 4 while reading it
    pred_addr = 6'd4; write_back_p = 1'b1; out2pred = 4'hF; put_out_addr = 6'd4; #2;
`ifdef PRED_BYPASS_EN
    chk("byp_same_out", 32'(pred_out), 32'hF);
    chk("byp_same_ok", 32'(pred_ok), 32'd1);
`else
    chk("byp_same_out", 32'(pred_out), 32'h0);
    chk("byp_same_ok", 32'(pred_ok), 32'd0);
`endif
    tick();
    write_back_p = 1'b0; #2;
    chk("byp_next_out", 32'(pred_out), 32'hF);
    chk("byp_next_ok", 32'(pred_ok), 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      in_sel       = NCH'($urandom_range(0, 7));
      ch_p_in      = (NCH*PW)'($urandom);
      put_in_addr  = AW'($urandom_range(0, 15));
      write_back_p = ($urandom_range(0, 2) == 0);
      out2pred     = PW'($urandom);
      put_out_addr = AW'($urandom_range(0, 15));
      clr_en       = ($urandom_range(0, 2) == 0);
      clr_addr     = AW'($urandom_range(0, 15));
      pred_addr    = AW'($urandom_range(0, 15));
      #2;
      chk_read("rnd");
      tick();
    end
    idle_inputs();

    // fill every entry: count reaches DEPTH without wrapping
    for (int i = 0; i < DEPTH; i++) begin
      write_back_p = 1'b1; out2pred = PW'(i); put_out_addr = AW'(i);
      tick();
    end
    idle_inputs(); pred_addr = 6'd63; #2;
    chk("full_cnt", 32'(valid_cnt), 32'd64);
    chk("full_out", 32'(pred_out), 32'hF);
    for (int i = 0; i < DEPTH; i++) begin
      clr_en = 1'b1; clr_addr = AW'(i);
      tick();
    end
    idle_inputs(); #2;
    chk("empty_cnt", 32'(valid_cnt), 32'd0);
    chk("empty_out", 32'(pred_out), 32'hF);
    chk("empty_ok", 32'(pred_ok), 32'd0);

    // send with empty mask is ignored
    send_req = 1'b1; send_addr = 6'd7; send_ch = 3'b000;
    tick();
    #1;
    chk("nomask_busy", 32'(send_busy), 32'd0);

    // send from invalid entry 7 waits
    send_ch = 3'b101;
    tick();
    send_req = 1'b0; send_ch = '0;
    tick(); tick();
    chk("wait_busy", 32'(send_busy), 32'd1);
    chk("wait_chv", 32'(ch_p_valid), 32'd0);
    chk("wait_chout", 32'(ch_p_out), 32'd0);
    in_sel = 3'b001; ch_p_in = 12'h006; put_in_addr = 6'd7;
    tick();
    idle_inputs();
    chk("wait2_chv", 32'(ch_p_valid), 32'd0);
    tick();
    chk("send_chv", 32'(ch_p_valid), 32'b101);
    chk("send_chout", 32'(ch_p_out), 32'h606);
    // a request while sending is ignored; data holds without ready
    send_req = 1'b1; send_addr = 6'd9; send_ch = 3'b010;
    tick();
    send_req = 1'b0; send_ch = '0;
    chk("hold_chv", 32'(ch_p_valid), 32'b101);
    chk("hold_chout", 32'(ch_p_out), 32'h606);
    ch_p_ready = 3'b001;
    tick();
    ch_p_ready = 3'b000;
    chk("hs0_chv", 32'(ch_p_valid), 32'b100);
    chk("hs0_chout", 32'(ch_p_out), 32'h600);
    chk("hs0_busy", 32'(send_busy), 32'd1);
    ch_p_ready = 3'b100;
    tick();
    ch_p_ready = 3'b000;
    chk("hs2_chv", 32'(ch_p_valid), 32'd0);
    chk("hs2_busy", 32'(send_busy), 32'd0);
    chk("hs2_chout", 32'(ch_p_out), 32'd0);
    tick();
    chk("post_busy", 32'(send_busy), 32'd0);

    // reset in the middle of a send
    send_req = 1'b1; send_addr = 6'd7; send_ch = 3'b010;
    tick();
    idle_inputs();
    tick();
    chk("pre_rst_chv", 32'(ch_p_valid), 32'b010);
    #2 RST = 1'b1;
    #1;
    chk("arst_chv", 32'(ch_p_valid), 32'd0);
    chk("arst_busy", 32'(send_busy), 32'd0);
    chk("arst_cnt", 32'(valid_cnt), 32'd0);
    chk("arst_chout", 32'(ch_p_out), 32'd0);
    m_reset();
    #2 RST = 1'b0;
    tick(); tick();
    chk("after_rst_chv", 32'(ch_p_valid), 32'd0);
    chk("after_rst_busy", 32'(send_busy), 32'd0);
    pred_addr = 6'd7; #1;
    chk_read("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pred_reg_file_n.md
PRED_REG_FILE_N -- requirements
Module: pred_reg_file_n

Interface
REQ-001 Parameter PW, default 4, predicate width in bits.
REQ-002 Parameter DEPTH, default 64, number of entries; AW = clog2(DEPTH).
REQ-003 Parameter NCH, default 3, number of neighbour/bus predicate channels.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 ch_p_in  in  NCH*PW  incoming predicates; channel k occupies bits [k*PW +: PW].
REQ-007 in_sel  in  NCH  one-hot channel select for the incoming write; all-zero means no write.
REQ-008 put_in_addr  in  AW  entry written from the selected channel.
REQ-009 write_back_p  in  1  FU write-back enable.
REQ-010 out2pred  in  PW  FU result predicate.
REQ-011 put_out_addr  in  AW  write-back entry.
REQ-012 clr_en  in  1  consume-clear enable.
REQ-013 clr_addr  in  AW  entry whose valid bit is cleared.
REQ-014 pred_addr  in  AW  FU read address.
REQ-015 pred_out  out  PW  FU read data.
REQ-016 pred_ok  out  1  the entry at pred_addr is valid.
REQ-017 send_req  in  1  start a send.
REQ-018 send_addr  in  AW  entry to send.
REQ-019 send_ch  in  NCH  destination channel mask.
REQ-020 ch_p_out  out  NCH*PW  outgoing predicates, same packing as ch_p_in.
REQ-021 ch_p_valid  out  NCH  per-channel valid.
REQ-022 ch_p_ready  in  NCH  per-channel ready.
REQ-023 send_busy  out  1  sender not IDLE.
REQ-024 valid_cnt  out  AW+1  number of valid entries.

Function
REQ-025 When in_sel is nonzero, the selected channel's data SHALL be written to put_in_addr and that entry's valid bit set; an in_sel value that is not one-hot SHALL perform no write.
REQ-026 When write_back_p=1, out2pred SHALL be written to put_out_addr and that entry's valid bit set.
REQ-027 If a channel write and a write-back target the same address in the same cycle, the write-back data SHALL win.
REQ-028 clr_en=1 SHALL clear the valid bit at clr_addr, but a set to the same address in the same cycle SHALL win (entry stays valid).
REQ-029 valid_cnt SHALL always equal the population count of the valid bits, updated in the same cycle as the bits; it never wraps, and its range is 0..DEPTH.
REQ-030 pred_out and pred_ok SHALL be combinational from the array contents and valid bit at pred_addr; pred_out is driven even when pred_ok=0.
REQ-031 The sender FSM SHALL have states IDLE, WAIT and SEND.
REQ-032 In IDLE, send_req=1 with nonzero send_ch SHALL latch send_addr and send_ch and move to WAIT; send_req with send_ch=0 SHALL be ignored.
REQ-033 In WAIT, once the latched entry is valid, its data SHALL be captured into the output register, ch_p_valid set for the latched channels, and the FSM SHALL move to SEND.
REQ-034 In SEND, each channel's valid bit SHALL drop in the cycle after it sees ready=1, and its data SHALL hold stable until then.
REQ-035 When the last pending channel handshakes, the FSM SHALL return to IDLE one cycle later.
REQ-036 send_req SHALL be ignored while not in IDLE.
REQ-037 ch_p_out SHALL be 0 on channels whose ch_p_valid=0.

Reset
REQ-038 While RST=1, all entries SHALL be 0, all valid bits 0, valid_cnt=0, the FSM IDLE, and ch_p_valid, ch_p_out and send_busy all 0.
REQ-039 Reset asserted mid-send SHALL abort the send immediately, with no further valid assertion.

Configuration
REQ-040 With PRED_BYPASS_EN defined, a write-back in the current cycle to pred_addr SHALL forward out2pred to pred_out with pred_ok=1 in the same cycle.
REQ-041 Without PRED_BYPASS_EN, pred_out and pred_ok SHALL reflect the stored state only, so the new value is visible one cycle after the write.

Verification
REQ-042 Scenario: in_sel=3'b010 with ch1 data 4'hA to addr 5, then pred_addr=5 -> pred_out=4'hA, pred_ok=1, valid_cnt=1.
REQ-043 Scenario: channel write 4'h3 and write-back 4'hC, both to addr 9 in one cycle -> entry 9 = 4'hC, valid_cnt increments by 1.
REQ-044 Scenario: clr_en and a write-back on addr 2 in the same cycle -> entry 2 remains valid and valid_cnt is unchanged.
REQ-045 Scenario: send_req on invalid addr 7 with send_ch=3'b101 -> FSM holds in WAIT; write 4'h6 to entry 7 -> ch0 and ch2 valid with data 4'h6; ready ch0 first, then ch2 -> send_busy low one cycle after the second handshake.
REQ-046 Scenario: RST pulsed during SEND -> ch_p_valid=0, send_busy=0 and valid_cnt=0 asynchronously.
REQ-047 Scenario: with PRED_BYPASS_EN, write-back 4'hF to addr 4 while pred_addr=4 -> pred_out=4'hF in the same cycle; without the macro, the old value is seen in that cycle.
